// File: rtl/spi_word_master.sv
// SPI mode-0 host sequencer: streams 64-bit words (least-significant byte first, MSB first within
// each byte) under one CS assertion per frame and captures the reply word shifted in on CIPO.
module spi_word_master #(
  parameter int unsigned CLKDIV   = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic [63:0] tx_data,
  input  logic        tx_last,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  input  logic        abort,
  output logic        busy,
  output logic        SCK,
  output logic        CS,
  output logic        COPI,
  input  logic        CIPO
);
  localparam int unsigned WORD_W = 64;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BIT_W  = 6;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n, bit_inc;
  logic [WORD_W-1:0] tx_word, tx_word_n, rx_shift, rx_shift_n, rx_data_n;
  logic              last_q, last_n;
  logic              sck_n, cs_n, copi_n, rx_valid_n, tx_ready_n, busy_n;
  logic              accept;

  // Wire bit n maps to data bit {n[5:3], 7 - n[2:0]}: byte order kept, bits reversed in a byte.
  function automatic logic [BIT_W-1:0] wire_idx(input logic [BIT_W-1:0] n);
    return {n[5:3], ~n[2:0]};
  endfunction

  assign accept  = tx_valid & tx_ready & ~abort;
  assign bit_inc = bit_cnt + BIT_W'(1);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_word  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      last_q   <= 1'b0;
      SCK      <= 1'b0;
      CS       <= 1'b1;
      COPI     <= 1'b0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      tx_word  <= tx_word_n;
      rx_shift <= rx_shift_n;
      rx_data  <= rx_data_n;
      last_q   <= last_n;
      SCK      <= sck_n;
      CS       <= cs_n;
      COPI     <= copi_n;
      rx_valid <= rx_valid_n;
      tx_ready <= tx_ready_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    tx_word_n  = tx_word;
    rx_shift_n = rx_shift;
    rx_data_n  = rx_data;
    last_n     = last_q;
    sck_n      = SCK;
    cs_n       = CS;
    copi_n     = COPI;
    rx_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          tx_word_n = tx_data;
          last_n    = tx_last;
          bit_cnt_n = '0;
          cs_n      = 1'b0;
          copi_n    = tx_data[wire_idx(BIT_W'(0))];
          cnt_n     = CNT_W'(CS_SETUP - 1);
          state_n   = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          cnt_n   = CNT_W'(CLKDIV - 1);
          state_n = SHIFT;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          cnt_n = CNT_W'(CLKDIV - 1);
          if (!SCK) begin
            sck_n = 1'b1;
            rx_shift_n[wire_idx(bit_cnt)] = CIPO;
          end else begin
            sck_n = 1'b0;
            if (bit_cnt == '1) begin
              // 64th falling edge: word complete
              rx_data_n  = rx_shift;
              rx_valid_n = 1'b1;
              if (last_q) begin
                cs_n    = 1'b1;
                copi_n  = 1'b0;
                cnt_n   = CNT_W'(CS_IDLE - 1);
                state_n = HOLD;
              end else begin
                state_n = NEXT;
              end
            end else begin
              bit_cnt_n = bit_inc;
              copi_n    = tx_word[wire_idx(bit_inc)];
            end
          end
        end
      end
      NEXT: begin
        if (accept) begin
          tx_word_n = tx_data;
          last_n    = tx_last;
          bit_cnt_n = '0;
          copi_n    = tx_data[wire_idx(BIT_W'(0))];
          cnt_n     = CNT_W'(CLKDIV - 1);
          state_n   = SHIFT;
        end
      end
      HOLD: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase

    // Abort drops the in-flight word and releases the bus
    if (abort && (state != IDLE)) begin
      state_n    = HOLD;
      sck_n      = 1'b0;
      cs_n       = 1'b1;
      copi_n     = 1'b0;
      rx_valid_n = 1'b0;
      rx_data_n  = rx_data;
      cnt_n      = CNT_W'(CS_IDLE - 1);
    end

    tx_ready_n = (state_n == IDLE) || (state_n == NEXT);
    busy_n     = (state_n != IDLE);
  end
endmodule

// File: tb/tb_spi_word_master.sv
// Scoreboard bench for spi_word_master: a CLKDIV=2 instance in loopback and a CLKDIV=1 instance
// fed a fixed reply pattern on CIPO.
module tb_spi_word_master;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        resetn;
  logic [63:0] tx_data, rx_data;
  logic        tx_last, tx_valid, tx_ready, rx_valid, abort, busy, SCK, CS, COPI, CIPO;
  logic [63:0] tx_data1, rx_data1;
  logic        tx_last1, tx_valid1, tx_ready1, rx_valid1, abort1, busy1, sck1, cs1, copi1, cipo1;

  assign CIPO = COPI;

  spi_word_master #(.CLKDIV(2), .CS_SETUP(2), .CS_IDLE(4)) dut (
    .CLK(CLK), .resetn(resetn), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .abort(abort), .busy(busy),
    .SCK(SCK), .CS(CS), .COPI(COPI), .CIPO(CIPO));

  spi_word_master #(.CLKDIV(1), .CS_SETUP(2), .CS_IDLE(4)) dut1 (
    .CLK(CLK), .resetn(resetn), .tx_data(tx_data1), .tx_last(tx_last1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .abort(abort1), .busy(busy1),
    .SCK(sck1), .CS(cs1), .COPI(copi1), .CIPO(cipo1));

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Bus tracker for the CLKDIV=2 instance
  int cyc, rise_total, high_total, cs_rise_total, cs_bad, cs_fall_cyc, first_rise_cyc, frame_rises;
  logic [63:0] cap;
  logic sck_prev, cs_prev;
  initial begin
    cyc = 0; rise_total = 0; high_total = 0; cs_rise_total = 0; cs_bad = 0;
    cs_fall_cyc = 0; first_rise_cyc = 0; frame_rises = 0; cap = '0;
    sck_prev = 1'b0; cs_prev = 1'b1;
    forever begin
      @(negedge CLK);
      cyc++;
      if (SCK === 1'b1 && sck_prev === 1'b0) begin
        rise_total++;
        cap = {cap[62:0], COPI};
        if (frame_rises == 0) first_rise_cyc = cyc;
        frame_rises++;
      end
      if (SCK === 1'b1) high_total++;
      if (SCK === 1'b1 && CS === 1'b1) cs_bad++;
      if (CS === 1'b0 && cs_prev === 1'b1) begin
        cs_fall_cyc = cyc;
        frame_rises = 0;
      end
      if (CS === 1'b1 && cs_prev === 1'b0) cs_rise_total++;
      sck_prev = SCK;
      cs_prev  = CS;
    end
  end

  // Reply model for the CLKDIV=1 instance: wire bits 32..63 are 1 (0xFFFFFFFF00000000)
  int cyc1, r1, rise1_total, first1, last1;
  logic s1prev;
  initial begin
    cyc1 = 0; r1 = 0; rise1_total = 0; first1 = 0; last1 = 0; s1prev = 1'b0; cipo1 = 1'b0;
    forever begin
      @(negedge CLK);
      cyc1++;
      if (cs1 !== 1'b0) r1 = 0;
      else if (sck1 === 1'b1 && s1prev === 1'b0) begin
        if (r1 == 0) first1 = cyc1;
        last1 = cyc1;
        r1++;
        rise1_total++;
      end
      s1prev = sck1;
      cipo1 = (r1 >= 32);
    end
  end

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge CLK);
      if (rx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rx_unexpected: actual rx_data %h required no rx_valid", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", rx_data, e);
        end
      end
    end
  end

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge CLK);
      if (rx_valid1 === 1'b1) begin
        if (exp_q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rx1_unexpected: actual rx_data %h required no rx_valid", rx_data1);
        end else begin
          e = exp_q1.pop_front();
          check("rx1_word", rx_data1, e);
        end
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic l, input bit expect_rx);
    int n;
    n = 0;
    @(negedge CLK);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
    check("send_ready", tx_ready, 1);
    if (expect_rx) exp_q.push_back(d);
    @(posedge CLK); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin @(negedge CLK); n++; end
    check("wait_idle", busy, 0);
  endtask

  int r0, h0, b0, c0, k, bad;

  initial begin
    resetn = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0; abort = 1'b0;
    tx_valid1 = 1'b0; tx_data1 = '0; tx_last1 = 1'b0; abort1 = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cs", CS, 1);
    check("rst_sck", SCK, 0);
    check("rst_copi", COPI, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    resetn = 1'b1;
    @(negedge CLK);

    // Single word, last=1
    r0 = rise_total; h0 = high_total; b0 = cs_bad;
    send(64'h0a00000000000001, 1'b1, 1'b1);
    k = 0;
    while (CS !== 1'b1 && k < 5000) begin @(negedge CLK); k++; end
    k = 0;
    while (tx_ready !== 1'b1 && k < 100) begin k++; @(negedge CLK); end
    check("t1_cs_high_before_ready", 64'(k), 4);
    check("t1_rises", 64'(rise_total - r0), 64);
    check("t1_sck_high_cycles", 64'(high_total - h0), 128);
    check("t1_cs_low_while_sck", 64'(cs_bad - b0), 0);
    check("t1_cs_to_first_rise", 64'(first_rise_cyc - cs_fall_cyc), 4);
    check("t1_first_byte", 64'(cap[63:56]), 64'b0000_0001);
    check("t1_last_byte", 64'(cap[7:0]), 64'b0000_1010);

    // Three-word loopback frame
    r0 = rise_total; b0 = cs_bad; c0 = cs_rise_total;
    send(64'h0100000000000001, 1'b0, 1'b1);
    send(64'h00000000005fffff, 1'b0, 1'b1);
    send(64'h0100000000000000, 1'b1, 1'b1);
    wait_idle();
    check("t2_rises", 64'(rise_total - r0), 192);
    check("t2_cs_single_release", 64'(cs_rise_total - c0), 1);
    check("t2_cs_low_while_sck", 64'(cs_bad - b0), 0);

    // Stall at the word boundary
    send(64'h1122334455667788, 1'b0, 1'b1);
    k = 0;
    while (tx_ready !== 1'b1 && k < 2000) begin @(negedge CLK); k++; end
    bad = 0;
    repeat (20) begin
      if (SCK !== 1'b0 || CS !== 1'b0 || tx_ready !== 1'b1) bad++;
      @(negedge CLK);
    end
    check("t3_stall_bus", 64'(bad), 0);
    tx_data = 64'h99aabbccddeeff00; tx_last = 1'b1; tx_valid = 1'b1;
    exp_q.push_back(64'h99aabbccddeeff00);
    @(posedge CLK); #1;
    tx_valid = 1'b0;
    k = 0;
    while (SCK !== 1'b1 && k < 50) begin @(posedge CLK); #1; k++; end
    check("t3_resume_latency", 64'(k), 2);
    wait_idle();

    // Abort after the 30th SCK rise
    send(64'h123456789abcdef0, 1'b0, 1'b0);
    r0 = rise_total;
    k = 0;
    while ((rise_total - r0) < 30 && k < 5000) begin @(negedge CLK); k++; end
    check("t4_reached_30", 64'(rise_total - r0), 30);
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    check("t4_cs_after_abort", CS, 1);
    check("t4_sck_after_abort", SCK, 0);
    @(negedge CLK);
    k = 0;
    while (busy === 1'b1 && k < 100) begin k++; @(negedge CLK); end
    check("t4_busy_hold_cycles", 64'(k), 4);
    check("t4_no_more_rises", 64'(rise_total - r0), 30);

    // Reset pulse mid-word, then a clean word
    send(64'hdeadbeefcafef00d, 1'b1, 1'b0);
    r0 = rise_total;
    k = 0;
    while ((rise_total - r0) < 10 && k < 5000) begin @(negedge CLK); k++; end
    resetn = 1'b0;
    #1;
    check("t5_rst_cs", CS, 1);
    check("t5_rst_sck", SCK, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rx_valid", rx_valid, 0);
    @(negedge CLK);
    resetn = 1'b1;
    r0 = rise_total;
    send(64'h8877665544332211, 1'b1, 1'b1);
    wait_idle();
    check("t5_clean_rises", 64'(rise_total - r0), 64);

    // CLKDIV=1 with a fixed reply pattern
    r0 = rise1_total;
    exp_q1.push_back(64'hFFFFFFFF00000000);
    @(negedge CLK);
    tx_data1 = 64'ha5a5a5a5a5a5a5a5; tx_last1 = 1'b1; tx_valid1 = 1'b1;
    k = 0;
    while (tx_ready1 !== 1'b1 && k < 100) begin @(negedge CLK); k++; end
    check("t6_ready", tx_ready1, 1);
    @(posedge CLK); #1;
    tx_valid1 = 1'b0;
    k = 0;
    while (busy1 !== 1'b0 && k < 2000) begin @(negedge CLK); k++; end
    check("t6_idle", busy1, 0);
    check("t6_rises", 64'(rise1_total - r0), 64);
    check("t6_sck_span", 64'(last1 - first1), 126);

    repeat (4) @(negedge CLK);
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    check("scoreboard1_drained", 64'(exp_q1.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual time limit reached required test completion");
    $fatal(1, "watchdog");
  end
endmodule
